// File: rtl/tmr_apb_slave_if.sv
// tmr_apb_slave_if: APB3/APB4 bus bundle between the bus master and the timer's APB slave front-end
// master drives psel/penable/pwrite/paddr/pwdata/pstrb; slave returns pready/prdata/pslverr
interface tmr_apb_slave_if #(
    parameter int ADDR_W = 12
);
    logic              tim_psel;
    logic              tim_penable;
    logic              tim_pwrite;
    logic [ADDR_W-1:0] tim_paddr;
    logic [31:0]       tim_pwdata;
    logic [3:0]        tim_pstrb;
    logic              tim_pready;
    logic [31:0]       tim_prdata;
    logic              tim_pslverr;

    modport master (
        output tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
        input  tim_pready, tim_prdata, tim_pslverr
    );

    modport slave (
        input  tim_psel, tim_penable, tim_pwrite, tim_paddr, tim_pwdata, tim_pstrb,
        output tim_pready, tim_prdata, tim_pslverr
    );
endinterface

// File: rtl/tmr_apb_slave.sv
// tmr_apb_slave: APB slave front-end turning transfers into one-cycle rd_en/wr_en register strobes
// Ports: sys_clk, sys_rst_n (sync, active-low); apb (slave modport: psel/penable/pwrite/paddr/
// pwdata/pstrb in, pready/prdata/pslverr out); addr/wdata/wstrb latched register-side bus;
// wr_en/rd_en one-cycle strobes; rdata combinational read-mux input.
// Define TMR_APB_SLVERR_EN to flag misaligned or unmapped addresses with pslverr.
module tmr_apb_slave #(
    parameter int          ADDR_W      = 12,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] LAST_ADDR   = 32'h18
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    tmr_apb_slave_if.slave apb,
    output logic [31:0]    addr,
    output logic [31:0]    wdata,
    output logic [3:0]     wstrb,
    output logic           wr_en,
    output logic           rd_en,
    input  logic [31:0]    rdata
);
`ifdef TMR_APB_SLVERR_EN
    localparam logic SLVERR_EN = 1'b1;
`else
    localparam logic SLVERR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic              wr_q;
    logic              err_q;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       paddr_ext;
    logic              err_c;

    assign paddr     = apb.tim_paddr;
    assign paddr_ext = 32'(paddr);
    assign err_c     = SLVERR_EN && (paddr[1:0] != 2'b00 || paddr_ext > LAST_ADDR);

    // Strobes are registered one edge ahead: they are loaded on the edge that leaves
    // cnt at 0, so they are high exactly in the ACCESS cycle where cnt == 0.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state           <= IDLE;
            cnt             <= '0;
            wr_q            <= 1'b0;
            err_q           <= 1'b0;
            addr            <= '0;
            wdata           <= '0;
            wstrb           <= '0;
            wr_en           <= 1'b0;
            rd_en           <= 1'b0;
            apb.tim_pready  <= 1'b0;
            apb.tim_pslverr <= 1'b0;
            apb.tim_prdata  <= '0;
        end else begin
            wr_en           <= 1'b0;
            rd_en           <= 1'b0;
            apb.tim_pready  <= 1'b0;
            apb.tim_pslverr <= 1'b0;
            case (state)
                IDLE: if (apb.tim_psel && !apb.tim_penable) begin
                    addr  <= paddr_ext;
                    wdata <= apb.tim_pwdata;
                    wstrb <= apb.tim_pstrb;
                    wr_q  <= apb.tim_pwrite;
                    err_q <= err_c;
                    cnt   <= 3'(WAIT_CYCLES);
                    state <= ACCESS;
                    if (WAIT_CYCLES == 0) begin
                        wr_en <= apb.tim_pwrite && !err_c;
                        rd_en <= !apb.tim_pwrite && !err_c;
                    end
                end
                ACCESS: if (!apb.tim_psel) begin
                    // Dropped select: abandon; a strobe not yet loaded never appears.
                    state <= IDLE;
                end else if (cnt != 3'd0) begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        wr_en <= wr_q && !err_q;
                        rd_en <= !wr_q && !err_q;
                    end
                end else begin
                    apb.tim_prdata  <= err_q ? 32'd0 : (wr_q ? apb.tim_prdata : rdata);
                    apb.tim_pready  <= 1'b1;
                    apb.tim_pslverr <= err_q;
                    state           <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tmr_apb_slave.sv
// tb_tmr_apb_slave: scoreboard bench for tmr_apb_slave with WAIT_CYCLES=0 and WAIT_CYCLES=3 instances
module tb_tmr_apb_slave;
    typedef struct {
        int          c;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } sexp_t;

    typedef struct {
        int          c;
        logic [31:0] p;
        logic        e;
    } rexp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    sexp_t       sq0[$], sq1[$];
    rexp_t       rq0[$], rq1[$];

    logic [31:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
    logic [3:0]  wstrb0, wstrb1;
    logic        wr0, rd0, wr1, rd1;

    tmr_apb_slave_if #(.ADDR_W(12)) a0 ();
    tmr_apb_slave_if #(.ADDR_W(12)) a1 ();

    tmr_apb_slave #(.ADDR_W(12), .WAIT_CYCLES(0), .LAST_ADDR(32'h18)) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .apb(a0),
        .addr(addr0), .wdata(wdata0), .wstrb(wstrb0), .wr_en(wr0), .rd_en(rd0), .rdata(rdata0)
    );

    tmr_apb_slave #(.ADDR_W(12), .WAIT_CYCLES(3), .LAST_ADDR(32'h18)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .apb(a1),
        .addr(addr1), .wdata(wdata1), .wstrb(wstrb1), .wr_en(wr1), .rd_en(rd1), .rdata(rdata1)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    endfunction

    task automatic mon(input int u, input logic w, input logic r, input logic rdy, input logic e,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] prd,
                       input logic [3:0] s);
        sexp_t se;
        rexp_t re;
        if (w || r) begin
            if ((u == 0 ? sq0.size() : sq1.size()) == 0) begin
                chk($sformatf("u%0d_unexpected_strobe", u), 32'({w, r}), 32'd0);
            end else begin
                if (u == 0) se = sq0.pop_front();
                else se = sq1.pop_front();
                chk($sformatf("u%0d_strobe_cycle", u), 32'(cyc), 32'(se.c));
                chk($sformatf("u%0d_strobe_kind", u), 32'({w, r}), 32'({se.w, !se.w}));
                chk($sformatf("u%0d_addr", u), a, se.a);
                chk($sformatf("u%0d_wdata", u), d, se.d);
                chk($sformatf("u%0d_wstrb", u), 32'(s), 32'(se.s));
            end
        end
        if (rdy) begin
            if ((u == 0 ? rq0.size() : rq1.size()) == 0) begin
                chk($sformatf("u%0d_unexpected_pready", u), 32'(rdy), 32'd0);
            end else begin
                if (u == 0) re = rq0.pop_front();
                else re = rq1.pop_front();
                chk($sformatf("u%0d_pready_cycle", u), 32'(cyc), 32'(re.c));
                chk($sformatf("u%0d_prdata", u), prd, re.p);
                chk($sformatf("u%0d_pslverr", u), 32'(e), 32'(re.e));
            end
        end
    endtask

    always @(negedge sys_clk) begin
        mon(0, wr0, rd0, a0.tim_pready, a0.tim_pslverr, addr0, wdata0, a0.tim_prdata, wstrb0);
        mon(1, wr1, rd1, a1.tim_pready, a1.tim_pslverr, addr1, wdata1, a1.tim_prdata, wstrb1);
    end

    task automatic drv(input int u, input logic s, input logic en, input logic w,
                       input logic [11:0] pa, input logic [31:0] pd, input logic [3:0] ps,
                       input logic [31:0] rd);
        if (u == 0) begin
            a0.tim_psel = s; a0.tim_penable = en; a0.tim_pwrite = w;
            a0.tim_paddr = pa; a0.tim_pwdata = pd; a0.tim_pstrb = ps; rdata0 = rd;
        end else begin
            a1.tim_psel = s; a1.tim_penable = en; a1.tim_pwrite = w;
            a1.tim_paddr = pa; a1.tim_pwdata = pd; a1.tim_pstrb = ps; rdata1 = rd;
        end
    endtask

    // Entered just after a rising edge; that cycle is T0.
    task automatic xfer(input int u, input logic w, input logic [11:0] pa, input logic [31:0] pd,
                        input logic [3:0] ps, input logic [31:0] rd, input logic [31:0] exp_prd,
                        input logic exp_err, input bit strobe, input bit b2b);
        int  wt;
        bit  seen;
        wt = (u == 0) ? 0 : 3;
        drv(u, 1'b1, 1'b0, w, pa, pd, ps, rd);
        if (strobe) begin
            if (u == 0) sq0.push_back('{cyc + 1 + wt, w, 32'(pa), pd, ps});
            else sq1.push_back('{cyc + 1 + wt, w, 32'(pa), pd, ps});
        end
        if (u == 0) rq0.push_back('{cyc + 2 + wt, exp_prd, exp_err});
        else rq1.push_back('{cyc + 2 + wt, exp_prd, exp_err});
        @(posedge sys_clk); #1;
        drv(u, 1'b1, 1'b1, w, pa, pd, ps, rd);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge sys_clk);
            seen = (u == 0) ? a0.tim_pready : a1.tim_pready;
        end
        if (!seen) chk($sformatf("u%0d_pready_timeout", u), 32'(seen), 32'd1);
        @(posedge sys_clk); #1;
        if (!b2b) drv(u, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drv(0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 32'h0);
        drv(1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 32'h0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_pready", 32'(a0.tim_pready), 32'd0);
        chk("rst_pslverr", 32'(a0.tim_pslverr), 32'd0);
        chk("rst_prdata", a0.tim_prdata, 32'd0);
        chk("rst_addr", addr0, 32'd0);
        chk("rst_wdata", wdata0, 32'd0);
        chk("rst_wstrb", 32'(wstrb0), 32'd0);
        chk("rst_strobes", 32'({wr0, rd0, wr1, rd1}), 32'd0);
        chk("rst_pready1", 32'(a1.tim_pready), 32'd0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        xfer(0, 1'b1, 12'h00C, 32'h0000_1234, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        xfer(1, 1'b0, 12'h004, 32'h0, 4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        xfer(0, 1'b1, 12'h014, 32'hA5A5_0014, 4'b0011, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        xfer(0, 1'b0, 12'h018, 32'h0, 4'h0, 32'h0000_0018, 32'h0000_0018, 1'b0, 1'b1, 1'b0);
        xfer(0, 1'b1, 12'h008, 32'h0000_0808, 4'b0000, 32'h0, 32'h0000_0018, 1'b0, 1'b1, 1'b0);
`ifdef TMR_APB_SLVERR_EN
        xfer(0, 1'b1, 12'h01C, 32'h0000_001C, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        xfer(0, 1'b0, 12'h006, 32'h0, 4'hF, 32'h0000_0055, 32'h0, 1'b1, 1'b0, 1'b0);
        xfer(0, 1'b0, 12'h01C, 32'h0, 4'hF, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
`else
        xfer(0, 1'b1, 12'h01C, 32'h0000_001C, 4'hF, 32'h0, 32'h0000_0018, 1'b0, 1'b1, 1'b0);
        xfer(0, 1'b0, 12'h006, 32'h0, 4'hF, 32'h0000_0055, 32'h0000_0055, 1'b0, 1'b1, 1'b0);
        xfer(0, 1'b0, 12'h01C, 32'h0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
`endif

        // Abort: select dropped in T1; a setup in T2 must be taken from IDLE.
        drv(1, 1'b1, 1'b0, 1'b1, 12'h008, 32'h1111_2222, 4'hF, 32'h0);
        @(posedge sys_clk); #1;
        drv(1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 32'h0);
        @(posedge sys_clk); #1;
        xfer(1, 1'b0, 12'h010, 32'h0, 4'hF, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b0);

        // Reset during T1 of a write on the wait-state instance.
        drv(1, 1'b1, 1'b0, 1'b1, 12'h00C, 32'h3333_4444, 4'hF, 32'h0);
        @(posedge sys_clk); #1;
        drv(1, 1'b1, 1'b1, 1'b1, 12'h00C, 32'h3333_4444, 4'hF, 32'h0);
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        drv(1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 32'h0);
        @(negedge sys_clk);
        chk("midrst_prdata", a1.tim_prdata, 32'd0);
        chk("midrst_addr", addr1, 32'd0);
        chk("midrst_wdata", wdata1, 32'd0);
        chk("midrst_pready", 32'(a1.tim_pready), 32'd0);
        repeat (8) @(posedge sys_clk);
        #1;
        xfer(1, 1'b1, 12'h000, 32'h0000_CAFE, 4'hF, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);

        repeat (4) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("strobes_left0", 32'(sq0.size()), 32'd0);
        chk("strobes_left1", 32'(sq1.size()), 32'd0);
        chk("readies_left0", 32'(rq0.size()), 32'd0);
        chk("readies_left1", 32'(rq1.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
